executor: RTL

EXECUTOR -- requirements
Module: executor

---
 rtl/executor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/executor.sv
// executor: single-issue execute stage (ALU, branch resolve, halt, illegal-op flag).
// Define EXECUTOR_MUL_EN to build the 32-cycle shift-add multiplier and its MUL_BUSY state.
module executor (
    input  logic         clock,
    input  logic         reset,
    input  logic [175:0] ID_EX,
    input  logic         id_valid,
    output logic         ex_ready,
    output logic [38:0]  EX_WB,
    output logic         branch_taken,
    output logic [31:0]  branch_target,
    output logic         halted,
    output logic         err
);
`ifdef EXECUTOR_MUL_EN
    typedef enum logic [1:0] {RUN = 2'd0, MUL_BUSY = 2'd1, HALTED = 2'd2} state_e;
`else
    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd2} state_e;
`endif

    state_e      state_q, state_d;
    logic [38:0] ex_wb_q, ex_wb_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic [31:0] instr, pc, rs, rt, imm;
    logic [15:0] ctrl;
    logic [4:0]  shamt;
    logic        accept;

    assign instr = ID_EX[31:0];
    assign pc    = ID_EX[63:32];
    assign rs    = ID_EX[95:64];
    assign rt    = ID_EX[127:96];
    assign imm   = ID_EX[159:128];
    assign ctrl  = ID_EX[175:160];
    assign shamt = instr[10:6];

    logic unused_bits;
    assign unused_bits = ^{instr[31:21], instr[5:0], imm[31:30]};

    assign ex_ready      = (state_q == RUN);
    assign accept        = id_valid && ex_ready;
    assign EX_WB         = ex_wb_q;
    assign branch_taken  = br_taken_q;
    assign branch_target = br_target_q;
    assign halted        = halted_q;
    assign err           = err_q;

    // Anything other than exactly one recognised control bit is illegal.
    logic        op_legal, op_we, op_br, op_mul, op_hlt;
    logic [31:0] op_res;
    logic [4:0]  op_dest;

    always_comb begin
        op_legal = 1'b1;
        op_we    = 1'b0;
        op_br    = 1'b0;
        op_mul   = 1'b0;
        op_hlt   = 1'b0;
        op_res   = '0;
        op_dest  = '0;
        case (ctrl)
            16'h0001: begin op_res = rs + rt;      op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0002: begin op_res = rs - rt;      op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0004: begin op_res = imm;          op_dest = instr[20:16]; op_we = 1'b1; end
            16'h0008: begin op_res = rt << shamt;  op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0010: begin op_res = rt >> shamt;  op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0020: begin op_res = rs & rt;      op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0040: begin op_res = rs | rt;      op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0080: begin op_res = rs ^ rt;      op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0100: op_br = 1'b1;
            16'h0200: op_br = (rs != rt);
            16'h0400: begin op_res = rs;           op_dest = instr[15:11]; op_we = 1'b1; end
            16'h0800: begin op_res = rs + imm;     op_dest = instr[20:16]; op_we = 1'b1; end
`ifdef EXECUTOR_MUL_EN
            16'h1000: begin op_mul = 1'b1;         op_dest = instr[15:11]; end
`endif
            16'h2000: op_hlt = 1'b1;
            16'h4000: begin end
            default:  op_legal = 1'b0;
        endcase
    end

`ifdef EXECUTOR_MUL_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [4:0]  mul_dest_q, mul_dest_d;
`endif

    always_comb begin
        state_d     = state_q;
        ex_wb_d     = '0;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        halted_d    = halted_q;
        err_d       = err_q;
`ifdef EXECUTOR_MUL_EN
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_dest_d = mul_dest_q;
`endif
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (!op_legal) begin
                        ex_wb_d = {1'b1, 1'b0, 5'd0, 32'd0};
                        err_d   = 1'b1;
`ifdef EXECUTOR_MUL_EN
                    end else if (op_mul) begin
                        state_d    = MUL_BUSY;
                        cnt_d      = 5'd0;
                        mcand_d    = rs;
                        mplier_d   = rt;
                        acc_d      = '0;
                        mul_dest_d = op_dest;
`endif
                    end else begin
                        ex_wb_d = {1'b1, op_we, op_dest, op_res};
                        if (op_br) begin
                            br_taken_d  = 1'b1;
                            br_target_d = pc + 32'd4 + {imm[29:0], 2'b00};
                        end
                        if (op_hlt) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
`ifdef EXECUTOR_MUL_EN
            // One partial product per cycle; the wrap from 31 closes the product.
            MUL_BUSY: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = RUN;
                    ex_wb_d = {1'b1, 1'b1, mul_dest_q, acc_d};
                end
            end
`endif
            default: begin end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            ex_wb_q     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
`ifdef EXECUTOR_MUL_EN
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_dest_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ex_wb_q     <= ex_wb_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
`ifdef EXECUTOR_MUL_EN
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mul_dest_q <= mul_dest_d;
`endif
        end
    end
endmodule
